serial_adder: RTL and testbench

Parametrised multi-cycle adder: generalises the single-bit full adder to WIDTH-bit operands processed DIGIT bits per clock, with a start/done handshake. It sits beside datapath blocks that need a low-area adder and can tolerate WIDTH/DIGIT cycles of latency. An optional compile-time subtract mode turns it into an adder/subtractor.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/serial_adder_fa_digit.sv | 28 ++
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial_adder block.
// Holds the FSM state encoding and the width helpers used to size the
// digit counter.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2 of n; 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Counter width for n states, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_fa_digit.sv
// fa_digit: combinational DIGIT-bit ripple of full adders.
// One digit of the serial datapath; the carry register lives in the parent.
module fa_digit
   import serial_adder_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] sum,
   output logic             co
);

   // Ripple the carry through the digit, LSB first.
   always_comb begin
      logic c;
      // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
      c   = ci;
      sum = '0;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i] = x[i] ^ y[i] ^ c;
         c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      co = c;
   end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder processing DIGIT bits per clock with a
// start/busy/done handshake; one result every N+1 cycles, N = WIDTH/DIGIT.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the sub port,
// which computes a + ~b + 1 (cin ignored) when sampled high with start.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   // Reject configurations the datapath cannot represent.
   if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder: WIDTH must be at least 2");
   end
   if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must divide WIDTH");
   end

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc;
   logic             carry;

   logic [DIGIT-1:0] dsum;
   logic             dco;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

   // Operand B and carry-in as captured on an accepted start.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   fa_digit #(
      .DIGIT (DIGIT)
   ) u_fa (
      .x   (op_a[DIGIT-1:0]),
      .y   (op_b[DIGIT-1:0]),
      .ci  (carry),
      .sum (dsum),
      .co  (dco)
   );

   // Sum digits enter from the MSB side so after N steps the LSB digit
   // has travelled down to bit 0.
   assign acc_next = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

   // Control FSM and datapath registers; outputs are registered here too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         op_a  <= '0;
         op_b  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_a  <= a;
                  op_b  <= b_load;
                  carry <= c_load;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               op_a  <= op_a >> DIGIT;
               op_b  <= op_b >> DIGIT;
               carry <= dco;
               acc   <= acc_next;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  s     <= acc_next;
                  cout  <= dco;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: one DIGIT=1 and one DIGIT=4 instance,
// scoreboard queues popped on each done pulse.
module tb_serial_adder;

   typedef struct {
      logic [7:0] s;
      logic       cout;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start1;
   logic       start4;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       sub;
   logic       busy1, done1, cout1;
   logic       busy4, done4, cout4;
   logic [7:0] s1, s4;

   int   n_cmp;
   int   n_bad;
   int   cyc;
   exp_t q1[$];
   exp_t q4[$];

   serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy1),
      .done  (done1),
      .s     (s1),
      .cout  (cout1)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy4),
      .done  (done4),
      .s     (s4),
      .cout  (cout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                  input logic c, input logic sb);
      logic [8:0] r;
      r = {1'b0, x} + {1'b0, y} + {8'd0, c};
`ifdef SERIAL_ADDER_SUB_EN
      if (sb) r = {1'b0, x} + {1'b0, ~y} + 9'd1;
`endif
      return '{s: r[7:0], cout: r[8]};
   endfunction

   // Scoreboard for the DIGIT=1 instance.
   always @(negedge clk) begin
      if (rst_n && done1) begin
         check("u1_busy_at_done", {31'd0, busy1}, 32'd0);
         if (q1.size() == 0) begin
            check("u1_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("u1_s", {24'd0, s1}, {24'd0, e.s});
            check("u1_cout", {31'd0, cout1}, {31'd0, e.cout});
         end
      end
   end

   // Scoreboard for the DIGIT=4 instance.
   always @(negedge clk) begin
      if (rst_n && done4) begin
         check("u4_busy_at_done", {31'd0, busy4}, 32'd0);
         if (q4.size() == 0) begin
            check("u4_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q4.pop_front();
            check("u4_s", {24'd0, s4}, {24'd0, e.s});
            check("u4_cout", {31'd0, cout4}, {31'd0, e.cout});
         end
      end
   end

   // One operation on instance 1 or 4; checks busy length and done pulse width.
   task automatic run_op(input int which, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tc, input logic ts, input int n_exp);
      int  nb;
      int  t;
      bit  seen;
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; sub = ts;
      if (which == 1) begin
         start1 = 1'b1;
         q1.push_back(model(ta, tb_v, tc, ts));
      end else begin
         start4 = 1'b1;
         q4.push_back(model(ta, tb_v, tc, ts));
      end
      nb = 0; t = 0; seen = 0;
      while (!seen && t < 100) begin
         @(negedge clk);
         if (t == 0) begin
            start1 = 1'b0;
            start4 = 1'b0;
         end
         t++;
         if ((which == 1) ? busy1 : busy4) nb++;
         if ((which == 1) ? done1 : done4) seen = 1;
      end
      check("done_seen", {31'd0, seen}, 32'd1);
      check("busy_cycles", nb, n_exp);
      @(negedge clk);
      check("done_one_cycle", {31'd0, (which == 1) ? done1 : done4}, 32'd0);
   endtask

   // Wait for done on instance 1, bounded.
   task automatic wait_done1(output int at_cyc);
      int t;
      t = 0;
      while (!done1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("wait_done1", {31'd0, done1}, 32'd1);
      at_cyc = cyc;
   endtask

   initial begin
      int t1, t2;
      n_cmp = 0; n_bad = 0; cyc = 0;
      rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_busy1", {31'd0, busy1}, 32'd0);
      check("rst_done1", {31'd0, done1}, 32'd0);
      check("rst_s1", {24'd0, s1}, 32'd0);
      check("rst_cout1", {31'd0, cout1}, 32'd0);
      check("rst_busy4", {31'd0, busy4}, 32'd0);
      check("rst_s4", {24'd0, s4}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full carry ripple, DIGIT=1: 8 RUN cycles.
      run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8);
      // DIGIT=4 with carry-in: 2 RUN cycles.
      run_op(4, 8'h5A, 8'h33, 1'b1, 1'b0, 2);
      run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, 8);

      // Result held after completion.
      repeat (3) @(negedge clk);
      check("hold_s1", {24'd0, s1}, 32'h00);
      check("hold_cout1", {31'd0, cout1}, 32'd1);

      // Back-to-back with start held high.
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
      q1.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
      @(negedge clk);
      a = 8'hF0; b = 8'h20;
      q1.push_back(model(8'hF0, 8'h20, 1'b0, 1'b0));
      wait_done1(t1);
      @(negedge clk);
      start1 = 1'b0;
      check("b2b_busy", {31'd0, busy1}, 32'd1);
      wait_done1(t2);
      check("b2b_spacing", t2 - t1, 9);
      @(negedge clk);

      // start mid-RUN is ignored.
      @(negedge clk);
      a = 8'h3C; b = 8'h0F; cin = 1'b0; start1 = 1'b1;
      q1.push_back(model(8'h3C, 8'h0F, 1'b0, 1'b0));
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; cin = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done1(t1);
      repeat (2) @(negedge clk);
      check("ignored_start_idle", {31'd0, busy1}, 32'd0);

      // Reset during RUN cycle 3 discards the operation.
      @(negedge clk);
      a = 8'h77; b = 8'h11; cin = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy1}, 32'd0);
      check("midrst_done", {31'd0, done1}, 32'd0);
      check("midrst_s", {24'd0, s1}, 32'd0);
      check("midrst_cout", {31'd0, cout1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1, 8'h01, 8'h01, 1'b0, 1'b0, 8);

`ifdef SERIAL_ADDER_SUB_EN
      // Subtract mode; cin must be ignored.
      run_op(1, 8'h05, 8'h07, 1'b1, 1'b1, 8);
      run_op(1, 8'h07, 8'h05, 1'b0, 1'b1, 8);
      run_op(4, 8'h07, 8'h05, 1'b1, 1'b1, 2);
      sub = 1'b0;
`endif

      repeat (3) @(negedge clk);
      check("sb1_empty", q1.size(), 0);
      check("sb4_empty", q4.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
